// File: rtl/pipe_ctrl_unit_pkg.sv
// Shared definitions for the pipeline stall/flush controller.
//   - FSM state encodings (RUN, FMASK, HWAIT, HALTED)
//   - Stall bus bit meanings (PIPELINE_STOP / PIPELINE_NOSTOP)
//   - idx_width(): width of an index able to address n entries (min 1 bit)
package pipe_ctrl_unit_pkg;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_FMASK  = 2'd1;
  localparam logic [1:0] ST_HWAIT  = 2'd2;
  localparam logic [1:0] ST_HALTED = 2'd3;

  localparam logic PIPELINE_STOP   = 1'b1;
  localparam logic PIPELINE_NOSTOP = 1'b0;

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pipe_prio_mask.sv
// Highest-set-bit priority encoder with thermometer output.
// Ports:
//   req_i    request vector, bit 0 = most upstream stage
//   therm_o  bits [k:0] set where k is the highest set request bit, else 0
//   idx_o    k (0 when no request)
//   any_o    at least one request set
module pipe_prio_mask
  import pipe_ctrl_unit_pkg::*;
#(
  parameter int NUM_STAGES = 4,
  parameter int IDX_W      = idx_width(NUM_STAGES)
) (
  input  logic [NUM_STAGES-1:0] req_i,
  output logic [NUM_STAGES-1:0] therm_o,
  output logic [IDX_W-1:0]      idx_o,
  output logic                  any_o
);

  logic run;

  always_comb begin
    idx_o = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (req_i[i]) idx_o = IDX_W'(i);
    end
  end

  // Downward OR-scan: a stage is covered once any stage at or above it requests.
  always_comb begin
    therm_o = '0;
    run     = 1'b0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      run        = run | req_i[i];
      therm_o[i] = run;
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Parametrised pipeline stall/flush controller for the dual-issue core.
// Maps per-stage stall/flush requests onto thermometer hold/clear enables,
// defers flushes that sit below an active stall, masks upstream stalls for a
// few cycles after a flush, handles debug halt/resume and runs a stall watchdog.
// Optional feature macro: STALL_PERF_CNT_EN (adds stall_cyc_cnt / flush_cnt).
// Ports:
//   clk            core clock
//   resetn         asynchronous active-low reset
//   stallreq       per-stage stall requests
//   flushreq       per-stage flush requests (stage i squashes [i:0])
//   halt_req       debug halt request
//   resume_req     debug resume request
//   stall          hold enables (combinational)
//   flush          clear enables (combinational)
//   halted         core halted by debug
//   stall_timeout  stall persisted for STALL_TIMEOUT cycles
//   stall_cyc_cnt  stalled-cycle counter     (STALL_PERF_CNT_EN only)
//   flush_cnt      applied-flush counter     (STALL_PERF_CNT_EN only)
module pipe_ctrl_unit
  import pipe_ctrl_unit_pkg::*;
#(
  parameter int NUM_STAGES     = 4,
  parameter int STALL_TIMEOUT  = 255,
  parameter int TO_W           = 8,
  parameter int FLUSH_MASK_CYC = 1,
  parameter int CNT_W          = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NUM_STAGES-1:0] stallreq,
  input  logic [NUM_STAGES-1:0] flushreq,
  input  logic                  halt_req,
  input  logic                  resume_req,
  output logic [NUM_STAGES-1:0] stall,
  output logic [NUM_STAGES-1:0] flush,
  output logic                  halted,
  output logic                  stall_timeout
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      stall_cyc_cnt,
  output logic [CNT_W-1:0]      flush_cnt
`endif
);

  localparam int IDX_W  = idx_width(NUM_STAGES);
  localparam int MASK_W = idx_width(FLUSH_MASK_CYC + 1);

  logic [1:0]            state_q, state_d;
  logic                  pend_vld_q, pend_vld_d;
  logic [IDX_W-1:0]      pend_idx_q, pend_idx_d;
  logic [MASK_W-1:0]     mask_cnt_q, mask_cnt_d;
  logic [IDX_W-1:0]      mask_idx_q, mask_idx_d;
  logic [TO_W-1:0]       wd_cnt_q, wd_cnt_d;
  logic                  timeout_q, timeout_d;

  logic                  halted_st;
  logic [NUM_STAGES-1:0] mask_therm;
  logic [NUM_STAGES-1:0] stall_req_eff;
  logic [NUM_STAGES-1:0] flush_req_eff;
  logic [NUM_STAGES-1:0] s_therm, f_therm;
  logic [IDX_W-1:0]      s_idx, f_idx;
  logic                  s_any, f_any;
  logic                  flush_apply, flush_defer;
  logic [NUM_STAGES-1:0] stall_int, flush_int;

  assign halted_st = (state_q == ST_HALTED);

  // Stages at or below the last flush index are still refilling with bubbles,
  // so their stall requests are stale while the mask window is open.
  always_comb begin
    mask_therm = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      mask_therm[i] = (IDX_W'(i) <= mask_idx_q);
    end
  end

  assign stall_req_eff = (mask_cnt_q != '0) ? (stallreq & ~mask_therm) : stallreq;

  // Folding the pending flush in as an extra request makes the encoder return
  // max(new, pending): a higher new index overrides, a lower one is absorbed.
  assign flush_req_eff = flushreq
                       | (pend_vld_q ? (NUM_STAGES'(1) << pend_idx_q) : '0);

  pipe_prio_mask #(
    .NUM_STAGES (NUM_STAGES),
    .IDX_W      (IDX_W)
  ) u_stall_prio (
    .req_i   (stall_req_eff),
    .therm_o (s_therm),
    .idx_o   (s_idx),
    .any_o   (s_any)
  );

  pipe_prio_mask #(
    .NUM_STAGES (NUM_STAGES),
    .IDX_W      (IDX_W)
  ) u_flush_prio (
    .req_i   (flush_req_eff),
    .therm_o (f_therm),
    .idx_o   (f_idx),
    .any_o   (f_any)
  );

  // A flush can only proceed when no stall sits above it; otherwise the
  // squash would clear a stage whose upstream neighbour is being held.
  assign flush_apply = !halted_st && f_any && (!s_any || (s_idx <= f_idx));
  assign flush_defer = !halted_st && f_any && !flush_apply;

  always_comb begin
    if (halted_st) begin
      stall_int = {NUM_STAGES{PIPELINE_STOP}};
      flush_int = '0;
    end else if (flush_apply) begin
      stall_int = {NUM_STAGES{PIPELINE_NOSTOP}};
      flush_int = f_therm;
    end else begin
      stall_int = s_therm;
      flush_int = '0;
    end
  end

  // Inputs may be live during reset, so the enables are forced quiet.
  assign stall         = resetn ? stall_int : '0;
  assign flush         = resetn ? flush_int : '0;
  assign halted        = halted_st;
  assign stall_timeout = timeout_q;

  // Pending flush and post-flush mask bookkeeping; frozen while halted.
  always_comb begin
    pend_vld_d = pend_vld_q;
    pend_idx_d = pend_idx_q;
    mask_cnt_d = mask_cnt_q;
    mask_idx_d = mask_idx_q;
    if (flush_apply) begin
      pend_vld_d = 1'b0;
      mask_cnt_d = MASK_W'(FLUSH_MASK_CYC);
      mask_idx_d = f_idx;
    end else if (!halted_st) begin
      if (flush_defer) begin
        pend_vld_d = 1'b1;
        pend_idx_d = f_idx;
      end
      if (mask_cnt_q != '0) mask_cnt_d = mask_cnt_q - MASK_W'(1);
    end
  end

  // FMASK mirrors an open mask window; the counter is what actually masks,
  // so masking also holds while waiting for a halt.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN, ST_FMASK: begin
        if (halt_req)                state_d = ST_HWAIT;
        else if (mask_cnt_d != '0)   state_d = ST_FMASK;
        else                         state_d = ST_RUN;
      end
      ST_HWAIT: begin
        if ((stall_int == '0) && (flush_int == '0)) state_d = ST_HALTED;
      end
      ST_HALTED: begin
        if (resume_req) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Watchdog holds its count while halted: that stall is intentional.
  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (!halted_st) begin
      if (stall_int != '0) begin
        if (wd_cnt_q != TO_W'(STALL_TIMEOUT)) wd_cnt_d = wd_cnt_q + TO_W'(1);
      end else begin
        wd_cnt_d = '0;
      end
    end
  end

  assign timeout_d = (wd_cnt_d == TO_W'(STALL_TIMEOUT));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_RUN;
      pend_vld_q <= 1'b0;
      pend_idx_q <= '0;
      mask_cnt_q <= '0;
      mask_idx_q <= '0;
      wd_cnt_q   <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_vld_q <= pend_vld_d;
      pend_idx_q <= pend_idx_d;
      mask_cnt_q <= mask_cnt_d;
      mask_idx_q <= mask_idx_d;
      wd_cnt_q   <= wd_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

`ifdef STALL_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cyc_cnt_q, stall_cyc_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cyc_cnt_d = stall_cyc_cnt_q;
    flush_cnt_d     = flush_cnt_q;
    if (!halted_st && (stall_int != '0)) stall_cyc_cnt_d = stall_cyc_cnt_q + CNT_W'(1);
    if (flush_apply)                     flush_cnt_d     = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cyc_cnt_q <= '0;
      flush_cnt_q     <= '0;
    end else begin
      stall_cyc_cnt_q <= stall_cyc_cnt_d;
      flush_cnt_q     <= flush_cnt_d;
    end
  end

  assign stall_cyc_cnt = stall_cyc_cnt_q;
  assign flush_cnt     = flush_cnt_q;
`else
  localparam int unused_cnt_w = CNT_W;
`endif

endmodule
